ex_mem_pipe_reg: RTL and testbench
==================================

# ex_mem_pipe_reg

Parametrised EX/MEM pipeline register with a valid/ready handshake and a two-entry skid buffer. It sits between the EX stage (ALU, branch adder) and the MEM stage, and lets MEM stall on multi-cycle memory accesses without dropping an instruction or losing throughput. It supports a synchronous flush for branch mispredicts. Memory-side control outputs are gated by valid, so a bubble never touches memory or the register file.

## Interface
Parameters:
- DATA_W, 32, width of ALU result, store data and branch target
- REG_ADDR_W, 5, destination register index width
- WB_W, 2, write-back control field width; bit 0 = RegWrite, bit 1 = MemToReg

Ports:
- Clk  in  1  rising-edge clock
- Rst  in  1  reset, synchronous, active-high
- Flush  in  1  kill all held and incoming entries this cycle
- in_valid  in  1  EX presents an instruction
- in_ready  out  1  register can accept this cycle
- WB_in  in  WB_W  write-back control
- Branch_in, MemRead_in, MemWrite_in  in  1 each  memory-stage control
- addResult_in  in  DATA_W  branch target
- ALUZero_in  in  1  ALU zero flag
- ALUResult_in  in  DATA_W  ALU result / memory address
- storeData_in  in  DATA_W  rt data for stores
- destReg_in  in  REG_ADDR_W  destination register (RegDst mux result)
- out_valid  out  1  output entry is valid
- out_ready  in  1  MEM consumes the output this cycle
- WB_out  out  WB_W  write-back control, RegWrite bit forced 0 when !out_valid
- Branch_out, MemRead_out, MemWrite_out  out  1 each  forced 0 when !out_valid
- PCSrc  out  1  out_valid & Branch & ALUZero of the output entry
- addResult_out, ALUResult_out, storeData_out  out  DATA_W  registered payload
- ALUZero_out  out  1  registered zero flag
- destReg_out  out  REG_ADDR_W  registered destination

## Operation
- Storage: main entry (drives outputs) and skid entry, each holding a valid bit and the full payload.
- in_ready = !skid_valid, driven straight from the register with no combinational path from out_ready.
- in_xfer = in_valid & in_ready. out_xfer = out_valid & out_ready.
- Main entry loads when !out_valid | out_ready:
  - If skid_valid: main <= skid, skid_valid <= 0.
  - Otherwise: main payload <= inputs, out_valid <= in_xfer.
- Main entry held (out_valid & !out_ready): if in_xfer, skid <= inputs and skid_valid <= 1.
- Flush has priority over any load in the same cycle: out_valid <= 0, skid_valid <= 0, and any concurrent in_xfer is discarded. Payload registers may keep stale data; all control outputs are gated by valid.
- Rst: out_valid = 0, skid_valid = 0, all payload = 0. Post-reset outputs: in_ready = 1 and every other output = 0.
- The payload passes through unmodified; the block performs no arithmetic. PCSrc is combinational from the main entry.

## Timing
- Latency: an instruction accepted at edge N appears on the outputs after edge N with out_valid = 1. That is 1 cycle.
- Throughput: 1 instruction per cycle while out_ready = 1.
- Stall: when out_ready falls, at most one more instruction is accepted (into the skid entry). in_ready drops in the cycle after that acceptance.
- Release: when out_ready rises, the skid entry moves to main on the next edge and in_ready returns to 1 after that edge. No bubble is inserted and ordering is preserved.
- Outputs are stable while out_valid & !out_ready.
- Rst or Flush asserted mid-stall empties both entries on that edge. in_ready = 1 the following cycle.

## Test plan
- Reset: hold Rst 2 cycles with in_valid = 1 -> out_valid = 0, MemWrite_out = 0, WB_out = 0, in_ready = 1. The first accepted ALUResult_in = 32'h10 appears 1 cycle after Rst falls.
- Streaming: 8 back-to-back instructions with ALUResult 1..8 and out_ready = 1 -> outputs 1..8 on consecutive cycles, 1-cycle latency, no gaps.
- Stall and skid: out_ready = 0 while presenting instructions A = 5 then B = 6 -> A held on the outputs, B captured, in_ready = 0 the next cycle. With out_ready = 1, A then B are output on consecutive cycles, and input C = 7 follows without loss.
- Flush: with both entries full, assert Flush together with in_valid -> next cycle out_valid = 0, MemRead_out = MemWrite_out = 0, PCSrc = 0, in_ready = 1. Nothing is emitted afterwards.
- PCSrc: Branch = 1, ALUZero = 1, addResult = 32'h40 -> PCSrc = 1 with addResult_out = 32'h40. With ALUZero = 0 -> PCSrc = 0. With out_valid = 0 -> PCSrc = 0.
- Width parameters: DATA_W = 64, REG_ADDR_W = 6; destReg 63 and ALUResult 64'hFFFF_0000_0000_0001 -> passed through bit-exact.

Source files
------------

// File: rtl/ex_mem_pipe_reg.sv
// EX/MEM pipeline register with a valid/ready handshake and a two-entry skid
// buffer. The main entry drives the outputs. The skid entry catches the one
// instruction that EX launches in the cycle MEM stalls, so in_ready never has
// a combinational path from out_ready. Memory and write-back controls are
// gated by out_valid, so a bubble or a flushed entry has no side effects.
module ex_mem_pipe_reg #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int WB_W       = 2
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  Flush,
    // EX side
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WB_W-1:0]       WB_in,
    input  logic                  Branch_in,
    input  logic                  MemRead_in,
    input  logic                  MemWrite_in,
    input  logic [DATA_W-1:0]     addResult_in,
    input  logic                  ALUZero_in,
    input  logic [DATA_W-1:0]     ALUResult_in,
    input  logic [DATA_W-1:0]     storeData_in,
    input  logic [REG_ADDR_W-1:0] destReg_in,
    // MEM side
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WB_W-1:0]       WB_out,
    output logic                  Branch_out,
    output logic                  MemRead_out,
    output logic                  MemWrite_out,
    output logic                  PCSrc,
    output logic [DATA_W-1:0]     addResult_out,
    output logic                  ALUZero_out,
    output logic [DATA_W-1:0]     ALUResult_out,
    output logic [DATA_W-1:0]     storeData_out,
    output logic [REG_ADDR_W-1:0] destReg_out
);

    // Everything that travels with one instruction.
    typedef struct packed {
        logic [WB_W-1:0]       wb;
        logic                  branch;
        logic                  mem_read;
        logic                  mem_write;
        logic [DATA_W-1:0]     add_result;
        logic                  alu_zero;
        logic [DATA_W-1:0]     alu_result;
        logic [DATA_W-1:0]     store_data;
        logic [REG_ADDR_W-1:0] dest_reg;
    } payload_t;

    payload_t main_q, main_d;
    payload_t skid_q, skid_d;
    logic     out_valid_q, out_valid_d;
    logic     skid_valid_q, skid_valid_d;

    payload_t in_pl;
    logic     in_xfer;
    logic     load_main;

    // Bundle the EX-side inputs into one payload word.
    always_comb begin
        in_pl            = '0;
        in_pl.wb         = WB_in;
        in_pl.branch     = Branch_in;
        in_pl.mem_read   = MemRead_in;
        in_pl.mem_write  = MemWrite_in;
        in_pl.add_result = addResult_in;
        in_pl.alu_zero   = ALUZero_in;
        in_pl.alu_result = ALUResult_in;
        in_pl.store_data = storeData_in;
        in_pl.dest_reg   = destReg_in;
    end

    // in_ready only reflects the skid flop, which keeps the ready path short.
    assign in_ready  = !skid_valid_q;
    assign in_xfer   = in_valid & in_ready;
    assign load_main = !out_valid_q | out_ready;

    // Next-state: refill main (from skid first), else park the input in skid.
    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;

        if (load_main) begin
            if (skid_valid_q) begin
                // Oldest instruction goes first; in_ready is low so no input
                // is accepted in this cycle.
                main_d       = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else begin
                main_d      = in_pl;
                out_valid_d = in_xfer;
            end
        end else if (in_xfer) begin
            // Main is stalled; the in-flight instruction lands in skid.
            skid_d       = in_pl;
            skid_valid_d = 1'b1;
        end

        // A mispredict kills both entries and whatever arrives with it.
        // Payload may go stale; valid gating hides it.
        if (Flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end
    end

    // State registers with synchronous reset clearing valids and payload.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            main_q       <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    // Output drive: controls gated by valid, payload passed through as held.
    always_comb begin
        out_valid     = out_valid_q;
        WB_out        = main_q.wb;
        WB_out[0]     = main_q.wb[0] & out_valid_q;   // RegWrite
        Branch_out    = main_q.branch & out_valid_q;
        MemRead_out   = main_q.mem_read & out_valid_q;
        MemWrite_out  = main_q.mem_write & out_valid_q;
        PCSrc         = out_valid_q & main_q.branch & main_q.alu_zero;
        addResult_out = main_q.add_result;
        ALUZero_out   = main_q.alu_zero;
        ALUResult_out = main_q.alu_result;
        storeData_out = main_q.store_data;
        destReg_out   = main_q.dest_reg;
    end

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Bench for ex_mem_pipe_reg: directed vector table, hand-written PCSrc and
// wide-parameter sequences, then random traffic against a queue model.
module tb_ex_mem_pipe_reg;

    typedef struct packed {
        logic [1:0]  wb;
        logic        br;
        logic        mr;
        logic        mw;
        logic [31:0] add;
        logic        z;
        logic [31:0] alu;
        logic [31:0] sd;
        logic [4:0]  rd;
    } pl_t;

    typedef struct {
        bit          rst;
        bit          flush;
        bit          iv;
        bit          ordy;
        logic [31:0] alu;
        bit          mw;
        bit          e_ir;
        bit          e_ov;
        logic [31:0] e_alu;
        bit          e_mw;
        bit          c_alu;
    } vec_t;

    logic        Clk = 1'b0;
    logic        Rst, Flush, in_valid, out_ready;
    logic        in_ready, out_valid;
    logic [1:0]  WB_in, WB_out;
    logic        Branch_in, MemRead_in, MemWrite_in, ALUZero_in;
    logic        Branch_out, MemRead_out, MemWrite_out, ALUZero_out, PCSrc;
    logic [31:0] addResult_in, ALUResult_in, storeData_in;
    logic [31:0] addResult_out, ALUResult_out, storeData_out;
    logic [4:0]  destReg_in, destReg_out;

    // Wide instance signals
    logic        w_flush, w_in_valid, w_out_ready, w_in_ready, w_out_valid;
    logic [1:0]  w_wb_in, w_wb_out;
    logic        w_br_in, w_mr_in, w_mw_in, w_z_in;
    logic        w_br_out, w_mr_out, w_mw_out, w_z_out, w_pcsrc;
    logic [63:0] w_add_in, w_alu_in, w_sd_in, w_add_out, w_alu_out, w_sd_out;
    logic [5:0]  w_rd_in, w_rd_out;

    int total = 0;
    int bad   = 0;
    pl_t mq[$];

    always #5 Clk = ~Clk;

    ex_mem_pipe_reg dut (
        .Clk(Clk), .Rst(Rst), .Flush(Flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .WB_in(WB_in), .Branch_in(Branch_in), .MemRead_in(MemRead_in),
        .MemWrite_in(MemWrite_in), .addResult_in(addResult_in),
        .ALUZero_in(ALUZero_in), .ALUResult_in(ALUResult_in),
        .storeData_in(storeData_in), .destReg_in(destReg_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .WB_out(WB_out), .Branch_out(Branch_out), .MemRead_out(MemRead_out),
        .MemWrite_out(MemWrite_out), .PCSrc(PCSrc),
        .addResult_out(addResult_out), .ALUZero_out(ALUZero_out),
        .ALUResult_out(ALUResult_out), .storeData_out(storeData_out),
        .destReg_out(destReg_out)
    );

    ex_mem_pipe_reg #(.DATA_W(64), .REG_ADDR_W(6), .WB_W(2)) dut64 (
        .Clk(Clk), .Rst(Rst), .Flush(w_flush),
        .in_valid(w_in_valid), .in_ready(w_in_ready),
        .WB_in(w_wb_in), .Branch_in(w_br_in), .MemRead_in(w_mr_in),
        .MemWrite_in(w_mw_in), .addResult_in(w_add_in),
        .ALUZero_in(w_z_in), .ALUResult_in(w_alu_in),
        .storeData_in(w_sd_in), .destReg_in(w_rd_in),
        .out_valid(w_out_valid), .out_ready(w_out_ready),
        .WB_out(w_wb_out), .Branch_out(w_br_out), .MemRead_out(w_mr_out),
        .MemWrite_out(w_mw_out), .PCSrc(w_pcsrc),
        .addResult_out(w_add_out), .ALUZero_out(w_z_out),
        .ALUResult_out(w_alu_out), .storeData_out(w_sd_out),
        .destReg_out(w_rd_out)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input pl_t p);
        WB_in        = p.wb;
        Branch_in    = p.br;
        MemRead_in   = p.mr;
        MemWrite_in  = p.mw;
        addResult_in = p.add;
        ALUZero_in   = p.z;
        ALUResult_in = p.alu;
        storeData_in = p.sd;
        destReg_in   = p.rd;
    endtask

    task automatic cyc();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    function automatic vec_t mk(bit rst, bit flush, bit iv, bit ordy, logic [31:0] alu, bit mw,
                                bit e_ir, bit e_ov, logic [31:0] e_alu, bit e_mw, bit c_alu);
        vec_t v;
        v.rst = rst; v.flush = flush; v.iv = iv; v.ordy = ordy; v.alu = alu; v.mw = mw;
        v.e_ir = e_ir; v.e_ov = e_ov; v.e_alu = e_alu; v.e_mw = e_mw; v.c_alu = c_alu;
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        pl_t p;
        // Idle the wide instance until its own test.
        w_flush = 0; w_in_valid = 0; w_out_ready = 1; w_wb_in = 0; w_br_in = 0;
        w_mr_in = 0; w_mw_in = 0; w_z_in = 0; w_add_in = 0; w_alu_in = 0;
        w_sd_in = 0; w_rd_in = 0;

        // rst flush iv ordy alu mw | ir ov alu mw chk_alu
        tbl.push_back(mk(1, 0, 1, 1, 32'h10, 1,  1, 0, 32'h0,  0, 1)); // reset
        tbl.push_back(mk(1, 0, 1, 1, 32'h10, 1,  1, 0, 32'h0,  0, 1));
        tbl.push_back(mk(0, 0, 1, 1, 32'h10, 1,  1, 1, 32'h10, 1, 1)); // first after reset
        for (int i = 1; i <= 8; i++)                                   // streaming
            tbl.push_back(mk(0, 0, 1, 1, i, 0,  1, 1, i, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0,       1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 5, 0,       1, 1, 5, 0, 1));      // A into main
        tbl.push_back(mk(0, 0, 1, 0, 6, 0,       0, 1, 5, 0, 1));      // B into skid
        tbl.push_back(mk(0, 0, 1, 0, 7, 0,       0, 1, 5, 0, 1));      // C refused, A held
        tbl.push_back(mk(0, 0, 1, 1, 7, 0,       1, 1, 6, 0, 1));      // A leaves, B to main
        tbl.push_back(mk(0, 0, 1, 1, 7, 0,       1, 1, 7, 0, 1));      // C follows
        tbl.push_back(mk(0, 0, 0, 1, 0, 0,       1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 9, 1,       1, 1, 9, 1, 1));      // fill main
        tbl.push_back(mk(0, 0, 1, 0, 10, 1,      0, 1, 9, 1, 1));      // fill skid
        tbl.push_back(mk(0, 1, 1, 0, 11, 1,      1, 0, 0, 0, 0));      // flush both full
        tbl.push_back(mk(0, 0, 0, 1, 0, 1,       1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 1,       1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 12, 0,      1, 1, 12, 0, 1));
        tbl.push_back(mk(0, 1, 1, 1, 13, 1,      1, 0, 0, 0, 0));      // flush kills in_xfer
        tbl.push_back(mk(0, 0, 0, 1, 0, 0,       1, 0, 0, 0, 0));

        Rst = 1; Flush = 0; in_valid = 0; out_ready = 1; drive('0);
        @(negedge Clk);
        foreach (tbl[k]) begin
            vec_t v;
            v = tbl[k];
            Rst = v.rst; Flush = v.flush; in_valid = v.iv; out_ready = v.ordy;
            p = '0;
            p.alu = v.alu; p.mw = v.mw; p.mr = v.mw; p.wb = v.mw ? 2'b11 : 2'b01;
            p.add = v.alu + 32'd100; p.sd = ~v.alu; p.rd = v.alu[4:0];
            drive(p);
            cyc();
            chk($sformatf("tbl%0d in_ready", k), in_ready, v.e_ir);
            chk($sformatf("tbl%0d out_valid", k), out_valid, v.e_ov);
            chk($sformatf("tbl%0d MemWrite_out", k), MemWrite_out, v.e_mw);
            chk($sformatf("tbl%0d MemRead_out", k), MemRead_out, v.e_mw);
            if (v.c_alu) chk($sformatf("tbl%0d ALUResult_out", k), ALUResult_out, v.e_alu);
            if (!v.e_ov) chk($sformatf("tbl%0d PCSrc", k), PCSrc, 0);
            if (v.rst) begin
                chk($sformatf("tbl%0d WB_out", k), WB_out, 0);
                chk($sformatf("tbl%0d destReg_out", k), destReg_out, 0);
                chk($sformatf("tbl%0d storeData_out", k), storeData_out, 0);
            end
        end

        // PCSrc sequence
        Flush = 0; out_ready = 1; in_valid = 1;
        p = '0; p.br = 1; p.z = 1; p.add = 32'h40; drive(p);
        cyc();
        chk("pcsrc taken", PCSrc, 1);
        chk("pcsrc addResult_out", addResult_out, 32'h40);
        chk("pcsrc Branch_out", Branch_out, 1);
        p.z = 0; p.add = 32'h44; drive(p);
        cyc();
        chk("pcsrc zero=0", PCSrc, 0);
        chk("pcsrc ALUZero_out", ALUZero_out, 0);
        in_valid = 0; p.z = 1; drive(p);
        cyc();
        chk("pcsrc invalid", PCSrc, 0);
        chk("pcsrc Branch_out invalid", Branch_out, 0);

        // Wide-parameter pass-through
        w_in_valid = 1; w_alu_in = 64'hFFFF_0000_0000_0001; w_rd_in = 6'd63;
        w_sd_in = 64'h8000_0000_0000_0003; w_add_in = 64'h1234_5678_9ABC_DEF0;
        cyc();
        w_in_valid = 0;
        chk("w64 out_valid", w_out_valid, 1);
        chk("w64 ALUResult_out", w_alu_out, 64'hFFFF_0000_0000_0001);
        chk("w64 destReg_out", w_rd_out, 63);
        chk("w64 storeData_out", w_sd_out, 64'h8000_0000_0000_0003);
        chk("w64 addResult_out", w_add_out, 64'h1234_5678_9ABC_DEF0);

        // Random traffic vs. a queue model: up to two instructions in flight,
        // oldest on the outputs, flush/reset empty it.
        Rst = 1; cyc(); Rst = 0;
        mq.delete();
        for (int n = 0; n < 600; n++) begin
            bit r, f, iv, ordy;
            int cnt;
            r    = ($urandom_range(0, 59) == 0);
            f    = ($urandom_range(0, 15) == 0);
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 1) == 1);
            p.wb = 2'($urandom); p.br = 1'($urandom); p.mr = 1'($urandom);
            p.mw = 1'($urandom); p.add = $urandom; p.z = 1'($urandom);
            p.alu = $urandom; p.sd = $urandom; p.rd = 5'($urandom);
            Rst = r; Flush = f; in_valid = iv; out_ready = ordy; drive(p);
            @(posedge Clk);
            cnt = mq.size();
            if (r || f) mq.delete();
            else begin
                if (cnt > 0 && ordy) void'(mq.pop_front());
                if (iv && cnt < 2) mq.push_back(p);
            end
            @(negedge Clk);
            chk("rnd in_ready", in_ready, mq.size() < 2);
            chk("rnd out_valid", out_valid, mq.size() > 0);
            if (mq.size() > 0) begin
                chk("rnd ALUResult_out", ALUResult_out, mq[0].alu);
                chk("rnd storeData_out", storeData_out, mq[0].sd);
                chk("rnd addResult_out", addResult_out, mq[0].add);
                chk("rnd destReg_out", destReg_out, mq[0].rd);
                chk("rnd WB_out", WB_out, mq[0].wb);
                chk("rnd MemRead_out", MemRead_out, mq[0].mr);
                chk("rnd MemWrite_out", MemWrite_out, mq[0].mw);
                chk("rnd Branch_out", Branch_out, mq[0].br);
                chk("rnd ALUZero_out", ALUZero_out, mq[0].z);
                chk("rnd PCSrc", PCSrc, mq[0].br & mq[0].z);
            end else begin
                chk("rnd idle ctrl", {WB_out[0], Branch_out, MemRead_out, MemWrite_out, PCSrc}, 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
